// File: rtl/spu_fetch.sv
// spu_fetch: instruction fetch stage for the dual-issue SPU pipeline.
// Keeps the 8-bit PC, fetches aligned instruction pairs into a small prefetch
// buffer and applies branch redirects from the branch unit's WB register.
// Optional build macro SPU_FETCH_PERF_EN adds three saturating perf counters.
module spu_fetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [7:0]  RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic [0:63] imem_data,
    input  logic        branch_taken,
    input  logic [7:0]  pc_wb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [0:31] inst0,
    output logic [0:31] inst1,
    output logic        slot0_valid,
    output logic [7:0]  pc_out,
    output logic        first
`ifdef SPU_FETCH_PERF_EN
    ,
    output logic [15:0] perf_redirects,
    output logic [15:0] perf_stall_cycles,
    output logic [15:0] perf_empty_cycles
`endif
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [7:0]       pc_q;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             inflight_q;
    logic             discard_q;
    logic [7:0]       req_pc_q;
    logic             req_odd_q;

    logic [0:63]      buf_data [DEPTH];
    logic [7:0]       buf_pc   [DEPTH];
    logic             buf_odd  [DEPTH];

    logic             credit_ok;
    logic             issue;
    logic             push;
    logic             pop;
    logic             show_head;
    logic [7:0]       pc_even;

    // Issue/push/pop decisions and head outputs
    always_comb begin
        pc_even   = {pc_q[7:1], 1'b0};
        // Credit counts buffered entries plus the pair still on its way back
        credit_ok = (32'(count_q) + 32'(inflight_q)) < DEPTH;
        issue     = !reset && !branch_taken && credit_ok;
        push      = inflight_q && !discard_q && !branch_taken;
        show_head = !reset && (count_q != '0);
        out_valid = show_head && !branch_taken;
        pop       = out_valid && out_ready;

        imem_req    = issue;
        imem_addr   = reset ? 8'h00 : pc_even;
        inst0       = '0;
        inst1       = '0;
        pc_out      = '0;
        slot0_valid = 1'b0;
        if (show_head) begin
            inst0       = buf_data[rd_ptr_q][0:31];
            inst1       = buf_data[rd_ptr_q][32:63];
            pc_out      = buf_pc[rd_ptr_q];
            slot0_valid = !buf_odd[rd_ptr_q];
        end
        first = slot0_valid;
    end

    // PC, pointers, occupancy and in-flight tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
            req_pc_q   <= '0;
            req_odd_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            // Wrong-path return still on the bus after a redirect is dropped
            discard_q  <= branch_taken && inflight_q;
            if (issue) begin
                req_pc_q  <= pc_even;
                req_odd_q <= pc_q[0];
                pc_q      <= pc_even + 8'd2;
            end
            if (branch_taken) begin
                pc_q     <= pc_wb;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: ;
                endcase
            end
        end
    end

    // Buffer storage; contents need no reset since the head is gated by count
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_data[wr_ptr_q] <= imem_data;
            buf_pc[wr_ptr_q]   <= req_pc_q;
            buf_odd[wr_ptr_q]  <= req_odd_q;
        end
    end

`ifdef SPU_FETCH_PERF_EN
    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_redirects    <= '0;
            perf_stall_cycles <= '0;
            perf_empty_cycles <= '0;
        end else begin
            if (branch_taken && perf_redirects != 16'hFFFF)
                perf_redirects <= perf_redirects + 16'd1;
            if (out_valid && !out_ready && perf_stall_cycles != 16'hFFFF)
                perf_stall_cycles <= perf_stall_cycles + 16'd1;
            if (!out_valid && !branch_taken && perf_empty_cycles != 16'hFFFF)
                perf_empty_cycles <= perf_empty_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_spu_fetch.sv
// Self-checking bench for spu_fetch: directed steps plus a randomized phase,
// checked against an in-order fetch-stream reference model.
module tb_spu_fetch;

    localparam int unsigned DEPTH    = 4;
    localparam logic [7:0]  RESET_PC = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [0:63] imem_data;
    logic        branch_taken;
    logic [7:0]  pc_wb;
    logic        out_valid;
    logic        out_ready;
    logic [0:31] inst0;
    logic [0:31] inst1;
    logic        slot0_valid;
    logic [7:0]  pc_out;
    logic        first;
`ifdef SPU_FETCH_PERF_EN
    logic [15:0] perf_redirects;
    logic [15:0] perf_stall_cycles;
    logic [15:0] perf_empty_cycles;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] salt;

    always #5 clk = ~clk;

    spu_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .branch_taken (branch_taken),
        .pc_wb        (pc_wb),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .inst0        (inst0),
        .inst1        (inst1),
        .slot0_valid  (slot0_valid),
        .pc_out       (pc_out),
`ifdef SPU_FETCH_PERF_EN
        .perf_redirects    (perf_redirects),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_empty_cycles (perf_empty_cycles),
`endif
        .first        (first)
    );

    function automatic logic [0:63] pair(input logic [7:0] a);
        return {salt, 8'h5A, a, ~salt, 8'hC3, a | 8'h01};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Instruction memory: pair one cycle after request, garbage otherwise
    always @(posedge clk) begin
        if (imem_req) imem_data <= pair(imem_addr);
        else          imem_data <= {$urandom, $urandom};
    end

    // Reference model: fetch and delivery are in-order streams from the last target
    logic [7:0]  exp_pc, req_pc;
    logic        exp_odd;
    logic [0:63] p;
    int          held, since, npops;
    bit          started = 0;
    bit          mv;

    always @(negedge clk) begin
        mv = 0;
        if (reset) begin
            started = 1;
            exp_pc  = RESET_PC & 8'hFE;
            exp_odd = RESET_PC[0];
            req_pc  = RESET_PC & 8'hFE;
            held    = 0;
            since   = 0;
        end else if (started) begin
            if (branch_taken) begin
                chk("bt_no_req", 64'(imem_req), 64'(0));
                chk("bt_no_valid", 64'(out_valid), 64'(0));
                exp_pc  = pc_wb & 8'hFE;
                exp_odd = pc_wb[0];
                req_pc  = pc_wb & 8'hFE;
                held    = 0;
                since   = 0;
            end else begin
                since++;
                mv = (since >= 3);
                chk("req_credit", 64'(imem_req), 64'(held < int'(DEPTH)));
                if (imem_req) begin
                    chk("req_addr", 64'(imem_addr), 64'(req_pc));
                    req_pc = req_pc + 8'd2;
                    held++;
                end
                chk("valid_latency", 64'(out_valid), 64'(mv));
                if (out_valid && out_ready) begin
                    p = pair(exp_pc);
                    chk("pop_pc", 64'(pc_out), 64'(exp_pc));
                    chk("pop_inst0", 64'(inst0), 64'(p[0:31]));
                    chk("pop_inst1", 64'(inst1), 64'(p[32:63]));
                    chk("pop_slot0", 64'(slot0_valid), 64'(!exp_odd));
                    chk("pop_first", 64'(first), 64'(!exp_odd));
                    exp_pc  = exp_pc + 8'd2;
                    exp_odd = 0;
                    held--;
                    npops++;
                end
            end
        end
    end

`ifdef SPU_FETCH_PERF_EN
    int m_red = 0, m_stall = 0, m_empty = 0;
    bit rst_prev = 0;
    always @(negedge clk) begin
        #1;
        if (started) begin
            if (rst_prev) begin
                m_red = 0; m_stall = 0; m_empty = 0;
            end
            chk("perf_redirects", 64'(perf_redirects), 64'(m_red));
            chk("perf_stall", 64'(perf_stall_cycles), 64'(m_stall));
            chk("perf_empty", 64'(perf_empty_cycles), 64'(m_empty));
            if (!reset) begin
                if (branch_taken) m_red++;
                if (mv && !out_ready) m_stall++;
                if (!mv && !branch_taken) m_empty++;
            end
        end
        rst_prev = reset;
    end
`endif

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, 64'(imem_req), 64'(0));
        chk({tag, "_addr"}, 64'(imem_addr), 64'(0));
        chk({tag, "_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_inst0"}, 64'(inst0), 64'(0));
        chk({tag, "_inst1"}, 64'(inst1), 64'(0));
        chk({tag, "_pc"}, 64'(pc_out), 64'(0));
        chk({tag, "_slot0"}, 64'(slot0_valid), 64'(0));
        chk({tag, "_first"}, 64'(first), 64'(0));
`ifdef SPU_FETCH_PERF_EN
        chk({tag, "_perf"}, 64'({perf_redirects, perf_stall_cycles, perf_empty_cycles}), 64'(0));
`endif
    endtask

    task automatic redirect(input logic [7:0] tgt);
        branch_taken = 1;
        pc_wb        = tgt;
        smp();
        tick();
        branch_taken = 0;
    endtask

    initial begin
        int nreq;
        int pops_before;
        salt         = 16'($urandom);
        npops        = 0;
        reset        = 1;
        branch_taken = 1;   // ignored while in reset
        pc_wb        = 8'h55;
        out_ready    = 1;

        // Reset state
        tick();
        smp();
        chk_all_zero("reset");
        tick();
        tick();
        branch_taken = 0;
        reset        = 0;

        // First fetch latency from reset release
        smp();
        chk("c0_req", 64'(imem_req), 64'(1));
        chk("c0_addr", 64'(imem_addr), 64'(8'h00));
        chk("c0_valid", 64'(out_valid), 64'(0));
        tick();
        smp();
        chk("c1_addr", 64'(imem_addr), 64'(8'h02));
        chk("c1_valid", 64'(out_valid), 64'(0));
        tick();
        smp();
        chk("c2_valid", 64'(out_valid), 64'(1));
        chk("c2_pc", 64'(pc_out), 64'(8'h00));
        chk("c2_slot0", 64'(slot0_valid), 64'(1));
        chk("c2_first", 64'(first), 64'(1));
        tick();
        repeat (10) begin smp(); tick(); end

        // Stall from reset: exactly DEPTH requests, then in-order drain
        out_ready = 0;
        reset     = 1;
        tick();
        reset = 0;
        nreq  = 0;
        repeat (20) begin
            smp();
            if (imem_req) nreq++;
            tick();
        end
        chk("stall_reqs", 64'(nreq), 64'(DEPTH));
        smp();
        chk("stall_noreq", 64'(imem_req), 64'(0));
        chk("stall_valid", 64'(out_valid), 64'(1));
        tick();
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("drain_pc", 64'(pc_out), 64'(8'(2 * i)));
            if (i == 1) begin
                chk("resume_req", 64'(imem_req), 64'(1));
                chk("resume_addr", 64'(imem_addr), 64'(8'h08));
            end
            tick();
        end
        repeat (6) begin smp(); tick(); end

        // Redirect while the 0x0A request is in flight
        reset = 1;
        tick();
        reset = 0;
        for (int k = 0; k < 6; k++) begin
            smp();
            if (k == 5) chk("pre_bt_addr", 64'(imem_addr), 64'(8'h0A));
            tick();
        end
        redirect(8'h40);
        smp();
        chk("n1_valid", 64'(out_valid), 64'(0));
        chk("n1_req", 64'(imem_req), 64'(1));
        chk("n1_addr", 64'(imem_addr), 64'(8'h40));
        tick();
        smp();
        chk("n2_valid", 64'(out_valid), 64'(0));
        tick();
        smp();
        chk("n3_valid", 64'(out_valid), 64'(1));
        chk("n3_pc", 64'(pc_out), 64'(8'h40));
        tick();

        // Odd target
        redirect(8'h21);
        repeat (2) begin smp(); tick(); end
        smp();
        chk("odd_pc", 64'(pc_out), 64'(8'h20));
        chk("odd_slot0", 64'(slot0_valid), 64'(0));
        chk("odd_first", 64'(first), 64'(0));
        tick();
        smp();
        chk("odd_next_pc", 64'(pc_out), 64'(8'h22));
        chk("odd_next_slot0", 64'(slot0_valid), 64'(1));
        tick();

        // PC wrap
        redirect(8'hFC);
        repeat (2) begin smp(); tick(); end
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("wrap_pc", 64'(pc_out), 64'(8'(8'hFC + 8'(2 * i))));
            tick();
        end

        // Back-to-back redirects: second wins
        branch_taken = 1;
        pc_wb        = 8'h80;
        smp();
        tick();
        pc_wb = 8'h90;
        smp();
        chk("b2b_noreq", 64'(imem_req), 64'(0));
        tick();
        branch_taken = 0;
        smp();
        chk("b2b_addr", 64'(imem_addr), 64'(8'h90));
        tick();
        smp();
        tick();
        smp();
        chk("b2b_valid", 64'(out_valid), 64'(1));
        chk("b2b_pc", 64'(pc_out), 64'(8'h90));
        tick();

        // Randomized backpressure and redirects
        pops_before = npops;
        repeat (400) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            branch_taken = ($urandom_range(0, 19) == 0);
            pc_wb        = 8'($urandom);
            smp();
            tick();
        end
        branch_taken = 0;
        chk("random_pops_seen", 64'(npops > pops_before + 100), 64'(1));

        // Reset with a nearly full buffer and a request in flight
        out_ready = 0;
        reset     = 1;
        tick();
        reset = 0;
        repeat (4) begin smp(); tick(); end
        reset = 1;
        smp();
        tick();
        smp();
        chk_all_zero("midreset");
        tick();
        reset     = 0;
        out_ready = 1;
        smp();
        chk("rr_req", 64'(imem_req), 64'(1));
        chk("rr_addr", 64'(imem_addr), 64'(RESET_PC & 8'hFE));
        chk("rr_valid0", 64'(out_valid), 64'(0));
        tick();
        smp();
        chk("rr_valid1", 64'(out_valid), 64'(0));
        tick();
        smp();
        p = pair(RESET_PC & 8'hFE);
        chk("rr_valid2", 64'(out_valid), 64'(1));
        chk("rr_pc", 64'(pc_out), 64'(RESET_PC & 8'hFE));
        chk("rr_inst0", 64'(inst0), 64'(p[0:31]));
        tick();
        repeat (4) begin smp(); tick(); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
